// File: rtl/preprocess_control_cccp.sv
// ============================================================================
// preprocess_control_cccp: per-word header strobes for Ethernet/IPv4/CCCP
// packets with short-packet detection. Optional macro: CCCP_DETECT_EN. Rev 1.0
// ============================================================================
`default_nettype none

module preprocess_control_cccp #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  word_ETH_DST,
  output logic                  word_ETH_IP_VER,
  output logic                  word_IP_LEN_ID,
  output logic                  word_IP_FRAG_TTL_PROTO,
  output logic                  word_IP_CHECKSUM_SRC_HI,
  output logic                  word_IP_SRC_DST,
  output logic                  word_IP_DST_LO,
  output logic                  word_CCCP_TYPE_IDEN_CHECKSUM,
  output logic                  short_pkt,
  output logic [15:0]           short_pkt_cnt
);

  typedef enum logic [2:0] {
    SKIP_MOD_HDRS = 3'd0,
    WORD_1        = 3'd1,
    WORD_2        = 3'd2,
    WORD_3        = 3'd3,
    WORD_4        = 3'd4,
    WORD_5        = 3'd5,
    WAIT_EOP      = 3'd6
  } state_t;

  state_t state;

  // Only the control qualification is needed; the data bits are decoded downstream.
  logic unused_data;
  assign unused_data = ^in_data;

  // Gating with reset keeps every strobe low while reset is held.
  logic is_data;
  logic is_eop;
  assign is_data = reset && in_wr && (in_ctrl == '0);
  assign is_eop  = reset && in_wr && (in_ctrl != '0);

  logic word5_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= SKIP_MOD_HDRS;
      short_pkt_cnt <= '0;
    end else begin
      if (in_wr) begin
        case (state)
          SKIP_MOD_HDRS, WORD_1: if (in_ctrl == '0) state <= WORD_2;
          WORD_2:   state <= (in_ctrl != '0) ? SKIP_MOD_HDRS : WORD_3;
          WORD_3:   state <= (in_ctrl != '0) ? SKIP_MOD_HDRS : WORD_4;
          WORD_4:   state <= (in_ctrl != '0) ? SKIP_MOD_HDRS : WORD_5;
          WORD_5:   state <= (in_ctrl != '0) ? SKIP_MOD_HDRS : WAIT_EOP;
          WAIT_EOP: if (in_ctrl != '0) state <= SKIP_MOD_HDRS;
          default:  state <= SKIP_MOD_HDRS;
        endcase
      end
      if (short_pkt && (short_pkt_cnt != 16'hFFFF))
        short_pkt_cnt <= short_pkt_cnt + 16'd1;
    end
  end

  always_comb begin
    word_ETH_DST            = 1'b0;
    word_ETH_IP_VER         = 1'b0;
    word_IP_LEN_ID          = 1'b0;
    word_IP_FRAG_TTL_PROTO  = 1'b0;
    word_IP_CHECKSUM_SRC_HI = 1'b0;
    word_IP_SRC_DST         = 1'b0;
    word_IP_DST_LO          = 1'b0;
    word5_hit               = 1'b0;
    short_pkt               = 1'b0;
    if (is_data) begin
      case (state)
        SKIP_MOD_HDRS, WORD_1: word_ETH_DST = 1'b1;
        WORD_2: word_ETH_IP_VER = 1'b1;
        WORD_3: begin
          word_IP_LEN_ID         = 1'b1;
          word_IP_FRAG_TTL_PROTO = 1'b1;
        end
        WORD_4: begin
          word_IP_CHECKSUM_SRC_HI = 1'b1;
          word_IP_SRC_DST         = 1'b1;
        end
        WORD_5: begin
          word_IP_DST_LO = 1'b1;
          word5_hit      = 1'b1;
        end
        default: ;
      endcase
    end
    if (is_eop && (state == WORD_2 || state == WORD_3 ||
                   state == WORD_4 || state == WORD_5))
      short_pkt = 1'b1;
  end

`ifdef CCCP_DETECT_EN
  assign word_CCCP_TYPE_IDEN_CHECKSUM = word5_hit;
`else
  logic unused_word5;
  assign unused_word5 = word5_hit;
  assign word_CCCP_TYPE_IDEN_CHECKSUM = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_preprocess_control_cccp.sv
// ============================================================================
// tb_preprocess_control_cccp: directed-vector scoreboard bench. Rev 1.0
// ============================================================================
`default_nettype none

module tb_preprocess_control_cccp;

  logic        clk;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        word_ETH_DST, word_ETH_IP_VER, word_IP_LEN_ID, word_IP_FRAG_TTL_PROTO;
  logic        word_IP_CHECKSUM_SRC_HI, word_IP_SRC_DST, word_IP_DST_LO;
  logic        word_CCCP_TYPE_IDEN_CHECKSUM, short_pkt;
  logic [15:0] short_pkt_cnt;

  preprocess_control_cccp #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .in_data                      (in_data),
    .in_ctrl                      (in_ctrl),
    .in_wr                        (in_wr),
    .word_ETH_DST                 (word_ETH_DST),
    .word_ETH_IP_VER              (word_ETH_IP_VER),
    .word_IP_LEN_ID               (word_IP_LEN_ID),
    .word_IP_FRAG_TTL_PROTO       (word_IP_FRAG_TTL_PROTO),
    .word_IP_CHECKSUM_SRC_HI      (word_IP_CHECKSUM_SRC_HI),
    .word_IP_SRC_DST              (word_IP_SRC_DST),
    .word_IP_DST_LO               (word_IP_DST_LO),
    .word_CCCP_TYPE_IDEN_CHECKSUM (word_CCCP_TYPE_IDEN_CHECKSUM),
    .short_pkt                    (short_pkt),
    .short_pkt_cnt                (short_pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector: {8 strobes, short_pkt, short_pkt_cnt}
  logic [24:0] exp_q[$];
  logic [15:0] exp_cnt = 16'd0;
  int          checks  = 0;
  int          passed  = 0;
  int          vec     = 0;

  function automatic logic [7:0] grp_bits(input int grp);
    case (grp)
      1:       return 8'b1000_0000;
      2:       return 8'b0100_0000;
      3:       return 8'b0011_0000;
      4:       return 8'b0000_1100;
`ifdef CCCP_DETECT_EN
      5:       return 8'b0000_0011;
`else
      5:       return 8'b0000_0010;
`endif
      default: return 8'b0000_0000;
    endcase
  endfunction

  task automatic drive(input logic wr, input logic [7:0] ctrl, input int grp, input logic shrt);
    @(negedge clk);
    reset   = 1'b1;
    in_wr   = wr;
    in_ctrl = ctrl;
    in_data = {$urandom, $urandom};
    exp_q.push_back({grp_bits(grp), shrt, exp_cnt});
    if (shrt && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic rst_cycle(input logic wr, input logic [7:0] ctrl);
    @(negedge clk);
    reset   = 1'b0;
    in_wr   = wr;
    in_ctrl = ctrl;
    in_data = {$urandom, $urandom};
    exp_cnt = 16'd0;
    exp_q.push_back(25'd0);
  endtask

  task automatic hdr();             drive(1'b1, 8'hFF, 0, 1'b0);   endtask
  task automatic dw(input int grp); drive(1'b1, 8'h00, grp, 1'b0); endtask
  task automatic eop(input logic s); drive(1'b1, 8'h01, 0, s);     endtask
  task automatic idle();            drive(1'b0, 8'h00, 0, 1'b0);   endtask

  task automatic full_packet();
    hdr(); hdr();
    for (int i = 1; i <= 5; i++) dw(i);
    dw(0);
    eop(1'b0);
  endtask

  // Monitor: samples combinational strobes mid-cycle, away from the rising edge.
  initial begin
    logic [24:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {word_ETH_DST, word_ETH_IP_VER, word_IP_LEN_ID, word_IP_FRAG_TTL_PROTO,
                 word_IP_CHECKSUM_SRC_HI, word_IP_SRC_DST, word_IP_DST_LO,
                 word_CCCP_TYPE_IDEN_CHECKSUM, short_pkt, short_pkt_cnt};
        checks++;
        if (act_v === exp_v) passed++;
        else $display("FAIL vec%0d: strobes/short/cnt actual=%b/%b/%h required=%b/%b/%h",
                      vec, act_v[24:17], act_v[16], act_v[15:0],
                      exp_v[24:17], exp_v[16], exp_v[15:0]);
        vec++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; in_wr = 1'b0; in_ctrl = 8'h00; in_data = '0;
    // Reset state, including a data word presented while reset is held
    rst_cycle(1'b0, 8'h00);
    rst_cycle(1'b1, 8'h00);

    // Full packet with continuous writes
    full_packet();

    // Gap of three idle cycles between words 3 and 4, plus idles in WAIT_EOP
    hdr(); hdr(); dw(1); dw(2); dw(3);
    idle(); idle(); drive(1'b0, 8'hFF, 0, 1'b0);
    dw(4); dw(5); idle(); dw(0); idle(); eop(1'b0);

    // Short packet ending at word 4, then a normal packet
    hdr(); dw(1); dw(2); dw(3); eop(1'b1);
    full_packet();

    // Back-to-back: EOP followed directly by word 1 of the next packet
    dw(1); dw(2); dw(3); dw(4); dw(5); dw(0); eop(1'b0);
    full_packet();

    // Short packets ending at word 2 and at word 5
    dw(1); eop(1'b1);
    hdr(); dw(1); dw(2); dw(3); dw(4); eop(1'b1);
    idle();

    // Reset during word 3; the aborted packet's EOP must not count as short
    hdr(); dw(1); dw(2);
    rst_cycle(1'b1, 8'h00);
    eop(1'b0);
    full_packet();

    // Saturation: preload the counter at its maximum, then a short packet
    @(negedge clk);
    in_wr = 1'b0; in_ctrl = 8'h00;
    force dut.short_pkt_cnt = 16'hFFFF;
    #1;
    release dut.short_pkt_cnt;
    exp_cnt = 16'hFFFF;
    hdr(); dw(1); dw(2); eop(1'b1);
    idle();
    full_packet();
    idle();

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #5;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
